irq_pending_latch: RTL and testbench
====================================

Name: irq_pending_latch

Overview:
- Upstream front end of the interrupt path: synchronises raw asynchronous interrupt lines and converts rising edges into sticky pending bits.
- Applies an enable mask and drives the `interrupts` vector consumed by `priority_encoder`.
- Pending bits are cleared one at a time by a CPU acknowledge carrying the index that `priority_encoder` reported on `y`.

Parameters:
- N_IRQ, 4, number of interrupt sources; must be 2..16.
- SYNC_STAGES, 2, flip-flops in each input synchroniser; must be >= 2.
- ID_W, 2, width of `ack_id`; must equal ceil(log2(N_IRQ)).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- irq_raw  input  N_IRQ  asynchronous interrupt request lines; active high, edge-significant
- irq_mask  input  N_IRQ  per-source enable; 1 = enabled
- ack  input  1  acknowledge strobe, one cycle per acknowledge
- ack_id  input  ID_W  index of the source being acknowledged (the encoder's `y` value)
- pending  output  N_IRQ  registered sticky pending bits, unmasked
- interrupts  output  N_IRQ  pending & irq_mask; feeds the encoder's `interrupts` input
- any_irq  output  1  OR-reduction of `interrupts`

Behaviour:
- Reset: on a rising edge with rst=1, every synchroniser flop, every edge-history flop and `pending` clear to 0. Outputs are then `pending`=0, `interrupts`=0, `any_irq`=0. Reset overrides ack and edge detection in that cycle.
- Synchroniser: per source, a chain of SYNC_STAGES flops; s[i] is the last stage.
- Edge detect: h[i] <= s[i] every cycle. rise[i] = s[i] & ~h[i].
- Set latency (SYNC_STAGES=2): if irq_raw[i] is high at rising edges E0, E1 and E2, then `pending[i]` is 1 after E2. In general, `pending` rises after SYNC_STAGES+1 sampling edges.
- Pulses: a raw pulse shorter than one clock period may be missed; that is permitted. A level held high produces exactly one pending event.
- Falling edges and steady levels never set or clear `pending`.
- Masking: the mask does not gate capture. Edges on masked sources still set `pending[i]`.
- `interrupts` and `any_irq` are combinational from `pending` and `irq_mask`. A mask change is therefore visible in the same cycle, with no latency.
- Acknowledge: on a rising edge with ack=1, `pending[ack_id]` clears to 0. All other bits are untouched.
- Ack of a non-pending bit: no effect.
- ack_id >= N_IRQ: ignored.
- ack=0: `ack_id` is ignored.
- Simultaneous rise[i] and ack of i in the same cycle: set wins and `pending[i]` stays 1, so the new event is not lost.
- Simultaneous rises on several sources: all are latched in the same cycle.
- Reset release with irq_raw[i] held high: the synchronisers fill with 1s. Because h resets to 0, one pending event is latched SYNC_STAGES+1 edges after rst deasserts. This is intentional.
- Reset mid-operation: all pending events are discarded. In-flight synchroniser data is discarded.

Optional Feature:
- Macro: IRQ_OVERRUN_EN.
- Defined:
  - Adds output port `overrun` [N_IRQ], registered and reset to 0.
  - `overrun[i]` sets when rise[i] occurs while `pending[i]` is already 1 and no ack of i happens in that cycle.
  - `overrun[i]` clears together with `pending[i]` on ack of i.
  - If ack of i and rise[i] coincide, `overrun[i]` clears and `pending[i]` stays 1.
- Not defined: the port and its logic are absent. Pending-bit behaviour is identical in both builds.

Test Plan:
- Reset, then irq_raw=4'b0000 for 10 cycles -> `pending`=0, `interrupts`=0, `any_irq`=0 throughout.
- irq_mask=4'b1111; raise irq_raw[2] and hold -> `pending`=4'b0100 exactly after the 3rd sampling edge and not earlier. Keep the line high 20 cycles -> `pending` stays 4'b0100 and no further events. Ack with ack_id=2 -> `pending`=4'b0000 the next cycle.
- irq_mask=4'b0101; pulse irq_raw=4'b1111 for 2 cycles -> `pending`=4'b1111, `interrupts`=4'b0101. Set irq_mask=4'b1111 -> `interrupts`=4'b1111 in the same cycle. Ack ids 0,1,2,3 in sequence -> `pending` steps through 4'b1110, 4'b1100, 4'b1000, 4'b0000.
- `pending[1]`=1; irq_raw[1] falls, then rises so that rise[1] lands on the same edge as ack with ack_id=1 -> `pending[1]` remains 1. With IRQ_OVERRUN_EN defined, `overrun[1]`=0 after that edge.
- With IRQ_OVERRUN_EN defined: two separated pulses on irq_raw[3], no ack -> `pending[3]`=1 and `overrun[3]`=1. Ack with ack_id=3 -> both 0.
- Set `pending`=4'b1010, then assert rst for 1 cycle while ack=1 and ack_id=1 -> `pending`=0. With irq_raw=4'b0001 held through reset -> `pending`=4'b0001 exactly 3 edges after rst deasserts.

Source files
------------

// File: rtl/irq_pending_latch.sv
// irq_pending_latch: synchronise raw IRQ lines, latch rising edges as sticky
// pending bits, mask them. Define IRQ_OVERRUN_EN to add the overrun output.
module irq_pending_latch #(
  parameter int N_IRQ       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_raw,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             ack,
  input  logic [ID_W-1:0]  ack_id,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] interrupts,
`ifdef IRQ_OVERRUN_EN
  output logic             any_irq,
  output logic [N_IRQ-1:0] overrun
`else
  output logic             any_irq
`endif
);

  logic [SYNC_STAGES-1:0][N_IRQ-1:0] r_sync;
  logic [N_IRQ-1:0] r_hist;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] w_sync_out;
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_ack_vec;
  logic [N_IRQ-1:0] w_pending_nxt;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // Synchroniser chains plus one flop of edge history per source
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_hist <= '0;
    end else begin
      r_sync[0] <= irq_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      r_hist <= w_sync_out;
    end
  end

  // Rising-edge detect and one-hot decode of the acknowledged index
  always_comb begin
    w_rise    = w_sync_out & ~r_hist;
    w_ack_vec = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      w_ack_vec[i] = ack && (ack_id == ID_W'(i));
    end
  end

  // A new edge wins over a coinciding ack so the event is not lost
  assign w_pending_nxt = (r_pending & ~w_ack_vec) | w_rise;

  // Sticky pending register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign pending    = r_pending;
  assign interrupts = r_pending & irq_mask;
  assign any_irq    = |interrupts;

`ifdef IRQ_OVERRUN_EN
  logic [N_IRQ-1:0] r_overrun;

  // Flag a second edge arriving before the first was acknowledged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= '0;
    end else begin
      r_overrun <= (r_overrun | (w_rise & r_pending)) & ~w_ack_vec;
    end
  end

  assign overrun = r_overrun;
`endif

endmodule

// File: tb/tb_irq_pending_latch.sv
// tb_irq_pending_latch: directed stimulus, edge-history model, per-cycle
// compare plus literal checks pinning the expected behaviour.
module tb_irq_pending_latch;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_raw;
  logic [N-1:0]  irq_mask;
  logic          ack;
  logic [IW-1:0] ack_id;
  logic [N-1:0]  pending;
  logic [N-1:0]  interrupts;
  logic          any_irq;
`ifdef IRQ_OVERRUN_EN
  logic [N-1:0]  overrun;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  irq_pending_latch #(.N_IRQ(N), .SYNC_STAGES(SS), .ID_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_raw    (irq_raw),
    .irq_mask   (irq_mask),
    .ack        (ack),
    .ack_id     (ack_id),
    .pending    (pending),
    .interrupts (interrupts),
`ifdef IRQ_OVERRUN_EN
    .any_irq    (any_irq),
    .overrun    (overrun)
`else
    .any_irq    (any_irq)
`endif
  );

  always #5 clk = ~clk;

  // Model: keep the raw samples seen since reset. The line value that
  // reaches the edge detector at an edge is the sample from SS edges
  // earlier; a rise is that sample being 1 while the one before it was 0.
  logic [N-1:0] samp_q[$];
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_ovr  = '0;

  always @(posedge clk) begin
    logic [N-1:0] s_now, s_prev, rise, ackv;
    int n;
    if (rst) begin
      samp_q.delete();
      m_pend = '0;
      m_ovr  = '0;
    end else begin
      samp_q.push_back(irq_raw);
      if (samp_q.size() > SS + 2) void'(samp_q.pop_front());
      n      = samp_q.size();
      s_now  = (n >= SS + 1) ? samp_q[n-1-SS] : '0;
      s_prev = (n >= SS + 2) ? samp_q[n-2-SS] : '0;
      rise   = s_now & ~s_prev;
      ackv   = '0;
      if (ack && int'(ack_id) < N) ackv[ack_id] = 1'b1;
      m_ovr  = (m_ovr & ~ackv) | (rise & m_pend & ~ackv);
      m_pend = (m_pend & ~ackv) | rise;
    end
  end

  // Per-cycle compare on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (pending !== m_pend) begin
        errors++;
        $display("FAIL model_pending t=%0t got=%b exp=%b",
                 $time, pending, m_pend);
      end
      checks++;
      if (interrupts !== (m_pend & irq_mask)) begin
        errors++;
        $display("FAIL model_interrupts t=%0t got=%b exp=%b",
                 $time, interrupts, m_pend & irq_mask);
      end
      checks++;
      if (any_irq !== (|(m_pend & irq_mask))) begin
        errors++;
        $display("FAIL model_any_irq t=%0t got=%b exp=%b",
                 $time, any_irq, |(m_pend & irq_mask));
      end
`ifdef IRQ_OVERRUN_EN
      checks++;
      if (overrun !== m_ovr) begin
        errors++;
        $display("FAIL model_overrun t=%0t got=%b exp=%b",
                 $time, overrun, m_ovr);
      end
`endif
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic lit(input string name, input logic [N-1:0] got,
                     input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
    end
  endtask

  task automatic do_ack(input int id);
    ack    = 1'b1;
    ack_id = IW'(id);
    tick();
    ack    = 1'b0;
  endtask

  initial begin
    logic [N-1:0] exp_steps [4];
    exp_steps[0] = 4'b1110;
    exp_steps[1] = 4'b1100;
    exp_steps[2] = 4'b1000;
    exp_steps[3] = 4'b0000;

    rst = 1'b1; irq_raw = '0; irq_mask = '0; ack = 1'b0; ack_id = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    lit("reset_pending", pending, 4'b0000);
    lit("reset_any", {3'b0, any_irq}, 4'b0000);

    tick(10);
    lit("idle_pending", pending, 4'b0000);
    lit("idle_interrupts", interrupts, 4'b0000);

    irq_mask = 4'b1111;
    irq_raw  = 4'b0100;
    tick();
    lit("lat_e0", pending, 4'b0000);
    tick();
    lit("lat_e1", pending, 4'b0000);
    tick();
    lit("lat_e2", pending, 4'b0100);
    tick(20);
    lit("level_once", pending, 4'b0100);
    do_ack(2);
    lit("ack2", pending, 4'b0000);
    irq_raw = 4'b0000;
    tick(4);
    lit("fall_nop", pending, 4'b0000);

    do_ack(0);
    lit("ack_not_pending", pending, 4'b0000);

    irq_mask = 4'b0101;
    irq_raw  = 4'b1111;
    tick(2);
    irq_raw  = 4'b0000;
    tick(4);
    lit("multi_pending", pending, 4'b1111);
    lit("masked_ints", interrupts, 4'b0101);
    irq_mask = 4'b1111;
    #1;
    lit("mask_same_cycle", interrupts, 4'b1111);
    for (int id = 0; id < 4; id++) begin
      do_ack(id);
      lit("ack_step", pending, exp_steps[id]);
    end
    lit("ack_step_any", {3'b0, any_irq}, 4'b0000);

    irq_raw = 4'b0010;
    tick(5);
    lit("p1_set", pending, 4'b0010);
    irq_raw = 4'b0000;
    tick(3);
    irq_raw = 4'b0010;
    tick(2);
    ack    = 1'b1;
    ack_id = 2'd1;
    tick();
    ack    = 1'b0;
    lit("rise_vs_ack", pending, 4'b0010);
`ifdef IRQ_OVERRUN_EN
    lit("rise_vs_ack_ovr", overrun, 4'b0000);
`endif
    irq_raw = 4'b0000;
    tick(3);
    do_ack(1);
    lit("p1_clear", pending, 4'b0000);

    irq_raw = 4'b1000;
    tick(2);
    irq_raw = 4'b0000;
    tick(3);
    irq_raw = 4'b1000;
    tick(2);
    irq_raw = 4'b0000;
    tick(4);
    lit("two_pulses", pending, 4'b1000);
`ifdef IRQ_OVERRUN_EN
    lit("overrun_set", overrun, 4'b1000);
`endif
    do_ack(3);
    lit("ack3", pending, 4'b0000);
`ifdef IRQ_OVERRUN_EN
    lit("overrun_clr", overrun, 4'b0000);
`endif

    irq_raw = 4'b1010;
    tick(2);
    irq_raw = 4'b0000;
    tick(4);
    lit("pre_reset", pending, 4'b1010);
    irq_raw = 4'b0001;
    rst     = 1'b1;
    ack     = 1'b1;
    ack_id  = 2'd1;
    tick();
    rst = 1'b0;
    ack = 1'b0;
    lit("mid_reset", pending, 4'b0000);
    tick();
    lit("rel_e0", pending, 4'b0000);
    tick();
    lit("rel_e1", pending, 4'b0000);
    tick();
    lit("rel_e2", pending, 4'b0001);
    tick(5);
    lit("rel_hold", pending, 4'b0001);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
